eth_frame_stats: RTL and testbench



---
 rtl/eth_stats_pkg.sv | 14 +
 rtl/eth_frame_stats_counter.sv | 51 +++++
 rtl/eth_frame_stats.sv | 187 ++++++++++++++++++
 tb/tb_eth_frame_stats.sv | 384 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/eth_stats_pkg.sv
// eth_stats_pkg: shared width defaults and checksum event codes
// for the Ethernet receive statistics block.
package eth_stats_pkg;

    localparam int ETH_CNT_W  = 16;
    localparam int ETH_DATA_W = 32;

    typedef enum logic [1:0] {
        EV_NONE,
        EV_GOOD,
        EV_BAD
    } stat_ev_t;

endpackage

// File: rtl/eth_frame_stats_counter.sv
// stat_counter: one statistics counter with clear, saturate-or-wrap
// behaviour at all-ones and a sticky overflow flag.
module stat_counter
    import eth_stats_pkg::*;
#(
    parameter int CNT_WIDTH = ETH_CNT_W,
    parameter int SATURATE  = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 inc,
    input  logic                 clear,
    output logic [CNT_WIDTH-1:0] count,
    output logic                 ovf
);

    logic [CNT_WIDTH-1:0] count_q, count_d;
    logic                 ovf_q, ovf_d;

    // Clear beats an increment; at all-ones either hold or wrap, flag sticks
    always_comb begin
        count_d = count_q;
        ovf_d   = ovf_q;
        if (clear) begin
            count_d = '0;
            ovf_d   = 1'b0;
        end else if (inc) begin
            if (&count_q) begin
                ovf_d   = 1'b1;
                count_d = (SATURATE != 0) ? count_q : '0;
            end else begin
                count_d = count_q + 1'b1;
            end
        end
    end

    // Counter state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    assign count = count_q;
    assign ovf   = ovf_q;

endmodule

// File: rtl/eth_frame_stats.sv
// eth_frame_stats: per-channel receive frame / checksum statistics with
// an atomic snapshot bank feeding a registered channel-select mux.
module eth_frame_stats
    import eth_stats_pkg::*;
#(
    parameter int NUM_CH     = 2,
    parameter int CNT_WIDTH  = ETH_CNT_W,
    parameter int DATA_WIDTH = ETH_DATA_W,
    parameter int SATURATE   = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_CH-1:0]     axiiv,
    input  logic [NUM_CH-1:0]     done,
    input  logic [NUM_CH-1:0]     kill,
    input  logic                  agg_valid,
    input  logic [DATA_WIDTH-1:0] agg_data,
    input  logic                  clear,
    input  logic                  snap_req,
    output logic                  snap_valid,
    input  logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] sel,
    output logic [CNT_WIDTH-1:0]  frame_cnt,
    output logic [CNT_WIDTH-1:0]  good_cnt,
    output logic [CNT_WIDTH-1:0]  bad_cnt,
    output logic                  ovf,
    output logic [DATA_WIDTH-1:0] last_val
);

    localparam int SEL_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic [NUM_CH-1:0]     prev_v_q, prev_v_d;
    logic [NUM_CH-1:0]     frame_ev, good_ev, bad_ev;
    stat_ev_t              ck_ev [NUM_CH];

    logic [CNT_WIDTH-1:0]  live_frame [NUM_CH];
    logic [CNT_WIDTH-1:0]  live_good  [NUM_CH];
    logic [CNT_WIDTH-1:0]  live_bad   [NUM_CH];
    logic [NUM_CH-1:0]     ovf_frame, ovf_good, ovf_bad, ovf_live;
    logic [DATA_WIDTH-1:0] last_live_q, last_live_d;

    logic [CNT_WIDTH-1:0]  snap_frame_q [NUM_CH];
    logic [CNT_WIDTH-1:0]  snap_frame_d [NUM_CH];
    logic [CNT_WIDTH-1:0]  snap_good_q  [NUM_CH];
    logic [CNT_WIDTH-1:0]  snap_good_d  [NUM_CH];
    logic [CNT_WIDTH-1:0]  snap_bad_q   [NUM_CH];
    logic [CNT_WIDTH-1:0]  snap_bad_d   [NUM_CH];
    logic [NUM_CH-1:0]     snap_ovf_q, snap_ovf_d;
    logic [DATA_WIDTH-1:0] snap_last_q, snap_last_d;
    logic                  snap_valid_q, snap_valid_d;

    logic [CNT_WIDTH-1:0]  frame_cnt_q, frame_cnt_d;
    logic [CNT_WIDTH-1:0]  good_cnt_q, good_cnt_d;
    logic [CNT_WIDTH-1:0]  bad_cnt_q, bad_cnt_d;
    logic                  ovf_q, ovf_d;

    // Frame end on valid falling edge; kill dominates done
    always_comb begin
        prev_v_d = axiiv;
        frame_ev = prev_v_q & ~axiiv;
        good_ev  = '0;
        bad_ev   = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            ck_ev[c] = EV_NONE;
            if (kill[c]) begin
                ck_ev[c] = EV_BAD;
            end else if (done[c]) begin
                ck_ev[c] = EV_GOOD;
            end
            good_ev[c] = (ck_ev[c] == EV_GOOD);
            bad_ev[c]  = (ck_ev[c] == EV_BAD);
        end
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        stat_counter #(
            .CNT_WIDTH (CNT_WIDTH),
            .SATURATE  (SATURATE)
        ) u_frame (
            .clk   (clk),
            .rst   (rst),
            .inc   (frame_ev[c]),
            .clear (clear),
            .count (live_frame[c]),
            .ovf   (ovf_frame[c])
        );
        stat_counter #(
            .CNT_WIDTH (CNT_WIDTH),
            .SATURATE  (SATURATE)
        ) u_good (
            .clk   (clk),
            .rst   (rst),
            .inc   (good_ev[c]),
            .clear (clear),
            .count (live_good[c]),
            .ovf   (ovf_good[c])
        );
        stat_counter #(
            .CNT_WIDTH (CNT_WIDTH),
            .SATURATE  (SATURATE)
        ) u_bad (
            .clk   (clk),
            .rst   (rst),
            .inc   (bad_ev[c]),
            .clear (clear),
            .count (live_bad[c]),
            .ovf   (ovf_bad[c])
        );
    end

    assign ovf_live = ovf_frame | ovf_good | ovf_bad;

    // Snapshot takes pre-update live values; output mux reads the new bank
    always_comb begin
        last_live_d = last_live_q;
        if (clear) begin
            last_live_d = '0;
        end else if (agg_valid) begin
            last_live_d = agg_data;
        end

        snap_frame_d = snap_frame_q;
        snap_good_d  = snap_good_q;
        snap_bad_d   = snap_bad_q;
        snap_ovf_d   = snap_ovf_q;
        snap_last_d  = snap_last_q;
        snap_valid_d = snap_req;
        if (snap_req) begin
            snap_frame_d = live_frame;
            snap_good_d  = live_good;
            snap_bad_d   = live_bad;
            snap_ovf_d   = ovf_live;
            snap_last_d  = last_live_q;
        end

        frame_cnt_d = '0;
        good_cnt_d  = '0;
        bad_cnt_d   = '0;
        ovf_d       = 1'b0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (sel == SEL_W'(c)) begin
                frame_cnt_d = snap_frame_d[c];
                good_cnt_d  = snap_good_d[c];
                bad_cnt_d   = snap_bad_d[c];
                ovf_d       = snap_ovf_d[c];
            end
        end
    end

    // Edge history, last value, snapshot bank and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_v_q     <= '0;
            last_live_q  <= '0;
            snap_frame_q <= '{default: '0};
            snap_good_q  <= '{default: '0};
            snap_bad_q   <= '{default: '0};
            snap_ovf_q   <= '0;
            snap_last_q  <= '0;
            snap_valid_q <= 1'b0;
            frame_cnt_q  <= '0;
            good_cnt_q   <= '0;
            bad_cnt_q    <= '0;
            ovf_q        <= 1'b0;
        end else begin
            prev_v_q     <= prev_v_d;
            last_live_q  <= last_live_d;
            snap_frame_q <= snap_frame_d;
            snap_good_q  <= snap_good_d;
            snap_bad_q   <= snap_bad_d;
            snap_ovf_q   <= snap_ovf_d;
            snap_last_q  <= snap_last_d;
            snap_valid_q <= snap_valid_d;
            frame_cnt_q  <= frame_cnt_d;
            good_cnt_q   <= good_cnt_d;
            bad_cnt_q    <= bad_cnt_d;
            ovf_q        <= ovf_d;
        end
    end

    assign snap_valid = snap_valid_q;
    assign frame_cnt  = frame_cnt_q;
    assign good_cnt   = good_cnt_q;
    assign bad_cnt    = bad_cnt_q;
    assign ovf        = ovf_q;
    assign last_val   = snap_last_q;

endmodule

// File: tb/tb_eth_frame_stats.sv
// tb_eth_frame_stats: saturating and wrapping instances side by side,
// checked against a per-channel counting model of the statistics block.
module tb_eth_frame_stats;

    localparam int NUM_CH = 2;
    localparam int CW     = 4;
    localparam int DW     = 32;
    localparam int SEL_W  = 1;
    localparam int MAXV   = 15;
    localparam int OW     = 1 + 3 * CW + 1 + DW;

    logic              clk;
    logic              rst;
    logic [NUM_CH-1:0] axiiv, done, kill;
    logic              agg_valid;
    logic [DW-1:0]     agg_data;
    logic              clear, snap_req;
    logic [SEL_W-1:0]  sel;

    logic          sv_s, ov_s, sv_w, ov_w;
    logic [CW-1:0] fc_s, gc_s, bc_s, fc_w, gc_w, bc_w;
    logic [DW-1:0] lv_s, lv_w;
    logic [OW-1:0] obs_s, obs_w;

    assign obs_s = {sv_s, fc_s, gc_s, bc_s, ov_s, lv_s};
    assign obs_w = {sv_w, fc_w, gc_w, bc_w, ov_w, lv_w};

    eth_frame_stats #(
        .NUM_CH(NUM_CH), .CNT_WIDTH(CW), .DATA_WIDTH(DW), .SATURATE(1)
    ) dut_s (
        .clk(clk), .rst(rst), .axiiv(axiiv), .done(done), .kill(kill),
        .agg_valid(agg_valid), .agg_data(agg_data), .clear(clear),
        .snap_req(snap_req), .snap_valid(sv_s), .sel(sel),
        .frame_cnt(fc_s), .good_cnt(gc_s), .bad_cnt(bc_s),
        .ovf(ov_s), .last_val(lv_s)
    );

    eth_frame_stats #(
        .NUM_CH(NUM_CH), .CNT_WIDTH(CW), .DATA_WIDTH(DW), .SATURATE(0)
    ) dut_w (
        .clk(clk), .rst(rst), .axiiv(axiiv), .done(done), .kill(kill),
        .agg_valid(agg_valid), .agg_data(agg_data), .clear(clear),
        .snap_req(snap_req), .snap_valid(sv_w), .sel(sel),
        .frame_cnt(fc_w), .good_cnt(gc_w), .bad_cnt(bc_w),
        .ovf(ov_w), .last_val(lv_w)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int ncheck = 0;
    int nfail  = 0;

    // model: index 0 = saturating instance, 1 = wrapping instance
    int            m_frame [2][NUM_CH];
    int            m_good  [2][NUM_CH];
    int            m_bad   [2][NUM_CH];
    bit            m_ovf   [2][NUM_CH];
    int            s_frame [2][NUM_CH];
    int            s_good  [2][NUM_CH];
    int            s_bad   [2][NUM_CH];
    bit            s_ovf   [2][NUM_CH];
    bit            m_prev  [NUM_CH];
    logic [DW-1:0] m_last, s_last;
    logic [OW-1:0] exp_o [2];

    function automatic void model_zero();
        for (int s = 0; s < 2; s++) begin
            for (int c = 0; c < NUM_CH; c++) begin
                m_frame[s][c] = 0; m_good[s][c] = 0;
                m_bad[s][c] = 0;   m_ovf[s][c] = 0;
                s_frame[s][c] = 0; s_good[s][c] = 0;
                s_bad[s][c] = 0;   s_ovf[s][c] = 0;
            end
            exp_o[s] = '0;
        end
        for (int c = 0; c < NUM_CH; c++) m_prev[c] = 0;
        m_last = '0;
        s_last = '0;
    endfunction

    function automatic int nxt(input int s, input int v);
        if (v < MAXV) return v + 1;
        return (s == 1) ? 0 : MAXV;
    endfunction

    // advance the model by one clock with current inputs, then clock the DUT
    task automatic cycle();
        bit fe [NUM_CH];
        bit ge [NUM_CH];
        bit be [NUM_CH];
        int i;
        for (int c = 0; c < NUM_CH; c++) begin
            fe[c] = m_prev[c] && !axiiv[c];
            be[c] = kill[c];
            ge[c] = done[c] && !kill[c];
        end
        if (snap_req) s_last = m_last;
        for (int s = 0; s < 2; s++) begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (snap_req) begin
                    s_frame[s][c] = m_frame[s][c];
                    s_good[s][c]  = m_good[s][c];
                    s_bad[s][c]   = m_bad[s][c];
                    s_ovf[s][c]   = m_ovf[s][c];
                end
                if (clear) begin
                    m_frame[s][c] = 0; m_good[s][c] = 0;
                    m_bad[s][c] = 0;   m_ovf[s][c] = 0;
                end else begin
                    if (fe[c] && m_frame[s][c] == MAXV) m_ovf[s][c] = 1;
                    if (ge[c] && m_good[s][c] == MAXV)  m_ovf[s][c] = 1;
                    if (be[c] && m_bad[s][c] == MAXV)   m_ovf[s][c] = 1;
                    if (fe[c]) m_frame[s][c] = nxt(s, m_frame[s][c]);
                    if (ge[c]) m_good[s][c]  = nxt(s, m_good[s][c]);
                    if (be[c]) m_bad[s][c]   = nxt(s, m_bad[s][c]);
                end
            end
            i = int'(sel);
            if (i < NUM_CH)
                exp_o[s] = {snap_req, CW'(s_frame[s][i]), CW'(s_good[s][i]),
                            CW'(s_bad[s][i]), s_ovf[s][i], s_last};
            else
                exp_o[s] = {snap_req, {(3 * CW + 1){1'b0}}, s_last};
        end
        if (clear) m_last = '0;
        else if (agg_valid) m_last = agg_data;
        for (int c = 0; c < NUM_CH; c++) m_prev[c] = axiiv[c];
        @(posedge clk);
        #1;
    endtask

    task automatic frame(input int ch);
        axiiv[ch] = 1'b1;
        cycle();
        axiiv[ch] = 1'b0;
        cycle();
    endtask

    task automatic snap(input int ch);
        sel = SEL_W'(ch);
        snap_req = 1'b1;
        cycle();
        snap_req = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        cycle();
        clear = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        model_zero();
        #1;
        ncheck++;
        if (obs_s !== '0) begin
            nfail++;
            $display("FAIL reset_async_s: got %h want 0", obs_s);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        cycle();
        ncheck++;
        if (obs_s !== exp_o[0] || obs_s !== '0) begin
            nfail++;
            $display("FAIL reset_s: got %h want %h", obs_s, exp_o[0]);
        end
        ncheck++;
        if (obs_w !== exp_o[1] || obs_w !== '0) begin
            nfail++;
            $display("FAIL reset_w: got %h want %h", obs_w, exp_o[1]);
        end
    endtask

    task automatic test_frame_count();
        repeat (3) frame(0);
        frame(1);
        snap(0);
        ncheck++;
        if (obs_s !== exp_o[0] || fc_s !== 4'd3 || sv_s !== 1'b1) begin
            nfail++;
            $display("FAIL frames_ch0: got %h want %h", obs_s, exp_o[0]);
        end
        cycle();
        ncheck++;
        if (sv_s !== 1'b0 || sv_w !== 1'b0) begin
            nfail++;
            $display("FAIL snap_pulse: got %b/%b want 0", sv_s, sv_w);
        end
        sel = 1'b1;
        cycle();
        ncheck++;
        if (obs_s !== exp_o[0] || fc_s !== 4'd1) begin
            nfail++;
            $display("FAIL frames_ch1: got %h want %h", obs_s, exp_o[0]);
        end
    endtask

    task automatic test_checksum();
        do_clear();
        done[0] = 1'b1;
        cycle();
        done[0] = 1'b0;
        kill[0] = 1'b1;
        cycle();
        done[0] = 1'b1;
        cycle();
        done[0] = 1'b0;
        kill[0] = 1'b0;
        snap(0);
        ncheck++;
        if (obs_s !== exp_o[0] || gc_s !== 4'd1 || bc_s !== 4'd2
            || fc_s !== 4'd0) begin
            nfail++;
            $display("FAIL checksum: got %h want %h", obs_s, exp_o[0]);
        end
    endtask

    task automatic test_saturation();
        do_clear();
        repeat (17) frame(0);
        snap(0);
        ncheck++;
        if (obs_s !== exp_o[0] || fc_s !== 4'd15 || ov_s !== 1'b1) begin
            nfail++;
            $display("FAIL saturate: got %h want %h", obs_s, exp_o[0]);
        end
        ncheck++;
        if (obs_w !== exp_o[1] || fc_w !== 4'd1 || ov_w !== 1'b1) begin
            nfail++;
            $display("FAIL wrap: got %h want %h", obs_w, exp_o[1]);
        end
    endtask

    task automatic test_collision();
        do_clear();
        agg_valid = 1'b1;
        agg_data  = 32'h1234_5678;
        axiiv[0]  = 1'b1;
        cycle();
        axiiv[0]  = 1'b0;
        clear     = 1'b1;
        agg_data  = 32'hDEAD_BEEF;
        cycle();
        clear     = 1'b0;
        agg_valid = 1'b0;
        snap(0);
        ncheck++;
        if (obs_s !== exp_o[0] || fc_s !== 4'd0 || lv_s !== 32'd0
            || ov_s !== 1'b0) begin
            nfail++;
            $display("FAIL clear_wins: got %h want %h", obs_s, exp_o[0]);
        end
        frame(0);
        axiiv[0] = 1'b1;
        cycle();
        axiiv[0] = 1'b0;
        snap_req = 1'b1;
        cycle();
        ncheck++;
        if (obs_s !== exp_o[0] || fc_s !== 4'd1) begin
            nfail++;
            $display("FAIL snap_pre_edge: got %h want %h", obs_s, exp_o[0]);
        end
        cycle();
        snap_req = 1'b0;
        ncheck++;
        if (obs_s !== exp_o[0] || fc_s !== 4'd2 || sv_s !== 1'b1) begin
            nfail++;
            $display("FAIL snap_post_edge: got %h want %h", obs_s, exp_o[0]);
        end
        do_clear();
        cycle();
        ncheck++;
        if (obs_w !== exp_o[1] || fc_w !== 4'd2) begin
            nfail++;
            $display("FAIL clear_keeps_snap: got %h want %h", obs_w, exp_o[1]);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            axiiv     = NUM_CH'($urandom);
            done      = NUM_CH'($urandom);
            kill      = NUM_CH'($urandom) & NUM_CH'($urandom);
            agg_valid = ($urandom_range(0, 3) == 0);
            agg_data  = $urandom;
            clear     = ($urandom_range(0, 40) == 0);
            snap_req  = ($urandom_range(0, 3) == 0);
            sel       = SEL_W'($urandom);
            cycle();
            ncheck++;
            if (obs_s !== exp_o[0]) begin
                nfail++;
                $display("FAIL random_s[%0d]: got %h want %h", n, obs_s, exp_o[0]);
            end
            ncheck++;
            if (obs_w !== exp_o[1]) begin
                nfail++;
                $display("FAIL random_w[%0d]: got %h want %h", n, obs_w, exp_o[1]);
            end
        end
        axiiv = '0; done = '0; kill = '0;
        agg_valid = 1'b0; clear = 1'b0; snap_req = 1'b0;
    endtask

    task automatic test_mid_reset();
        agg_valid = 1'b1;
        agg_data  = 32'hA5A5_0F0F;
        cycle();
        agg_valid = 1'b0;
        snap(0);
        axiiv[0] = 1'b1;
        cycle();
        cycle();
        rst = 1'b1;
        model_zero();
        #1;
        ncheck++;
        if (obs_s !== '0 || obs_w !== '0) begin
            nfail++;
            $display("FAIL mid_reset_async: got %h want 0", obs_s);
        end
        axiiv[0] = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        cycle();
        cycle();
        snap(0);
        ncheck++;
        if (obs_s !== exp_o[0] || fc_s !== 4'd0 || lv_s !== 32'd0) begin
            nfail++;
            $display("FAIL mid_reset_frame: got %h want %h", obs_s, exp_o[0]);
        end
        axiiv[0] = 1'b1;
        rst = 1'b1;
        model_zero();
        @(posedge clk);
        #1;
        rst = 1'b0;
        cycle();
        axiiv[0] = 1'b0;
        cycle();
        snap(0);
        ncheck++;
        if (obs_s !== exp_o[0] || fc_s !== 4'd1) begin
            nfail++;
            $display("FAIL valid_at_release: got %h want %h", obs_s, exp_o[0]);
        end
        sel = 1'b1;
        cycle();
        ncheck++;
        if (obs_w !== exp_o[1] || fc_w !== 4'd0 || lv_w !== 32'd0) begin
            nfail++;
            $display("FAIL post_reset_ch1: got %h want %h", obs_w, exp_o[1]);
        end
    endtask

    initial begin
        rst = 1'b0;
        axiiv = '0; done = '0; kill = '0;
        agg_valid = 1'b0; agg_data = '0;
        clear = 1'b0; snap_req = 1'b0; sel = '0;
        model_zero();
        #2;
        test_reset();
        test_frame_count();
        test_checksum();
        test_saturation();
        test_collision();
        test_random();
        test_mid_reset();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 ncheck, nfail);
        $finish;
    end

endmodule
